// File: rtl/fpu_itof_pkg.sv
// Shared types and rounding-mode helper for the int-to-float operand stage.
package fpu_itof_pkg;

  localparam int unsigned ITOF_INT_W = 64;
  localparam int unsigned ITOF_TAG_W = 4;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;
  localparam logic [2:0] RM_DYN = 3'd7;

  typedef struct packed {
    logic [ITOF_INT_W-1:0] a;
    logic                  signed_in;
    logic [2:0]            rm;
    logic                  illegal;
    logic [ITOF_TAG_W-1:0] tag;
  } itof_req_t;

  typedef struct packed {
    logic [2:0] rm;
    logic       illegal;
  } rm_res_t;

  // Static modes pass through, DYN takes frm; anything unresolvable is illegal with rm forced to RNE.
  function automatic rm_res_t resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
    rm_res_t res;
    res.rm      = RM_RNE;
    res.illegal = 1'b1;
    if (rm <= RM_RMM) begin
      res.rm      = rm;
      res.illegal = 1'b0;
    end else if ((rm == RM_DYN) && (frm <= RM_RMM)) begin
      res.rm      = frm;
      res.illegal = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/itof_skid_buf.sv
// Two-entry in-order valid/ready FIFO of itof_req_t with flush; head payload is read straight from storage registers.
module itof_skid_buf
  import fpu_itof_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush_i,
  input  logic      in_valid_i,
  output logic      in_ready_o,
  input  itof_req_t in_data_i,
  output logic      out_valid_o,
  input  logic      out_ready_i,
  output itof_req_t out_data_o
);

  localparam int unsigned CNT_W = 2;

  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  itof_req_t        mem_q [2];
  logic             push, pop;

  assign in_ready_o  = (count_q < CNT_W'(2)) && !flush_i;
  assign out_valid_o = (count_q != '0) && !flush_i;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign out_data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: rtl/itof_operand_stage.sv
// Operand staging ahead of the int-to-float converter: extends the source, resolves the rounding mode, buffers two requests.
module itof_operand_stage
  import fpu_itof_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned INT_W = ITOF_INT_W,
  parameter int unsigned TAG_W = ITOF_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_operand,
  input  logic             in_is_word,
  input  logic             in_is_unsigned,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [2:0]       frm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_a,
  output logic             out_signed_in,
  output logic [2:0]       out_rm,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [INT_W-1:0] ext_a;
  rm_res_t          rm_res;
  itof_req_t        req, head;

  // W forms take only bits [31:0]; the signedness of the source picks the fill.
  always_comb begin
    ext_a = in_operand[INT_W-1:0];
    if (in_is_word) begin
      if (in_is_unsigned) ext_a = INT_W'(in_operand[31:0]);
      else                ext_a = INT_W'($signed(in_operand[31:0]));
    end
  end

  assign rm_res = resolve_rm(in_rm, frm);

  always_comb begin
    req           = '0;
    req.a         = ITOF_INT_W'(ext_a);
    req.signed_in = !in_is_unsigned;
    req.rm        = rm_res.rm;
    req.illegal   = rm_res.illegal;
    req.tag       = ITOF_TAG_W'(in_tag);
  end

  itof_skid_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (req),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (head)
  );

  assign out_a         = INT_W'(head.a);
  assign out_signed_in = head.signed_in;
  assign out_rm        = head.rm;
  assign out_illegal   = head.illegal;
  assign out_tag       = TAG_W'(head.tag);

endmodule

// File: tb/tb_itof_operand_stage.sv
// Bench for itof_operand_stage: queue-based reference model checked every cycle, plus directed literal checks.
module tb_itof_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_operand = '0;
  logic        in_is_word = 1'b0;
  logic        in_is_unsigned = 1'b0;
  logic [2:0]  in_rm = '0;
  logic [3:0]  in_tag = '0;
  logic [2:0]  frm = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_a;
  logic        out_signed_in;
  logic [2:0]  out_rm;
  logic        out_illegal;
  logic [3:0]  out_tag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  itof_operand_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_operand     (in_operand),
    .in_is_word     (in_is_word),
    .in_is_unsigned (in_is_unsigned),
    .in_rm          (in_rm),
    .in_tag         (in_tag),
    .frm            (frm),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_a          (out_a),
    .out_signed_in  (out_signed_in),
    .out_rm         (out_rm),
    .out_illegal    (out_illegal),
    .out_tag        (out_tag)
  );

  typedef struct {
    logic [63:0] a;
    logic        s;
    logic [2:0]  rm;
    logic        ill;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [63:0] op, input logic w, input logic u,
                                 input logic [2:0] rm, input logic [2:0] f, input logic [3:0] tag);
    exp_t e;
    logic [63:0] lo;
    lo = {32'h0, op[31:0]};
    if (!w)                 e.a = op;
    else if (u || !op[31])  e.a = lo;
    else                    e.a = lo | 64'hFFFF_FFFF_0000_0000;
    e.s   = !u;
    e.tag = tag;
    e.rm  = 3'd0;
    e.ill = 1'b0;
    if (rm < 3'd5)                  e.rm = rm;
    else if (rm == 3'd7 && f < 3'd5) e.rm = f;
    else                             e.ill = 1'b1;
    return e;
  endfunction

  // Reference model: a plain queue of at most two expected entries.
  always @(posedge clk or negedge rst_n) begin
    bit push, pop;
    if (!rst_n) begin
      q.delete();
    end else begin
      push = in_valid && (q.size() < 2) && !flush;
      pop  = (q.size() != 0) && out_ready && !flush;
      if (flush) q.delete();
      else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(model(in_operand, in_is_word, in_is_unsigned, in_rm, frm, in_tag));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_a", out_a, 64'd0);
      chk("rst_payload", {57'd0, out_signed_in, out_rm, out_illegal, out_tag[0]}, 64'd0);
      chk("rst_tag", 64'(out_tag), 64'd0);
    end else begin
      chk("in_ready", 64'(in_ready), 64'((q.size() < 2) && !flush));
      chk("out_valid", 64'(out_valid), 64'((q.size() != 0) && !flush));
      if (q.size() != 0 && !flush) begin
        chk("out_a", out_a, q[0].a);
        chk("out_signed_in", 64'(out_signed_in), 64'(q[0].s));
        chk("out_rm", 64'(out_rm), 64'(q[0].rm));
        chk("out_illegal", 64'(out_illegal), 64'(q[0].ill));
        chk("out_tag", 64'(out_tag), 64'(q[0].tag));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] op, input logic w, input logic u,
                       input logic [2:0] rm, input logic [3:0] tag, input logic [2:0] f);
    in_valid       = 1'b1;
    in_operand     = op;
    in_is_word     = w;
    in_is_unsigned = u;
    in_rm          = rm;
    in_tag         = tag;
    frm            = f;
  endtask

  task automatic push1(input logic [63:0] op, input logic w, input logic u,
                       input logic [2:0] rm, input logic [3:0] tag, input logic [2:0] f);
    drive(op, w, u, rm, tag, f);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle;
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    // Extension
    push1(64'h0000_0000_8000_0000, 1'b1, 1'b0, 3'd0, 4'd1, 3'd0);
    chk("lit_sext_a", out_a, 64'hFFFF_FFFF_8000_0000);
    chk("lit_sext_s", 64'(out_signed_in), 64'd1);
    push1(64'h0000_0000_8000_0000, 1'b1, 1'b1, 3'd0, 4'd2, 3'd0);
    chk("lit_zext_a", out_a, 64'h0000_0000_8000_0000);
    chk("lit_zext_s", 64'(out_signed_in), 64'd0);

    // RM resolution
    push1(64'd5, 1'b0, 1'b0, 3'd7, 4'd3, 3'd3);
    chk("lit_dyn3_rm", 64'(out_rm), 64'd3);
    chk("lit_dyn3_ill", 64'(out_illegal), 64'd0);
    push1(64'd5, 1'b0, 1'b0, 3'd7, 4'd4, 3'd6);
    chk("lit_dyn6_rm", 64'(out_rm), 64'd0);
    chk("lit_dyn6_ill", 64'(out_illegal), 64'd1);
    push1(64'd5, 1'b0, 1'b0, 3'd5, 4'd5, 3'd0);
    chk("lit_rm5_ill", 64'(out_illegal), 64'd1);
    idle();

    // frm sampled only at push
    out_ready = 1'b0;
    push1(64'd9, 1'b0, 1'b0, 3'd7, 4'd6, 3'd2);
    frm = 3'd6;
    tick();
    @(negedge clk);
    chk("lit_frm_hold_rm", 64'(out_rm), 64'd2);
    chk("lit_frm_hold_tag", 64'(out_tag), 64'd6);
    out_ready = 1'b1;
    idle();

    // Backpressure
    out_ready = 1'b0;
    drive(64'd1, 1'b0, 1'b0, 3'd0, 4'd1, 3'd0); tick();
    drive(64'd2, 1'b0, 1'b0, 3'd0, 4'd2, 3'd0); tick();
    drive(64'd3, 1'b0, 1'b0, 3'd0, 4'd3, 3'd0); tick(); tick();
    @(negedge clk);
    chk("lit_bp_in_ready", 64'(in_ready), 64'd0);
    chk("lit_bp_head", 64'(out_tag), 64'd1);
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("lit_bp_tag2", 64'(out_tag), 64'd2);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_bp_tag3", 64'(out_tag), 64'd3);
    chk("lit_bp_valid3", 64'(out_valid), 64'd1);
    idle();

    // Flush with both sides requesting
    out_ready = 1'b0;
    drive(64'd4, 1'b0, 1'b0, 3'd0, 4'd4, 3'd0); tick();
    drive(64'd5, 1'b0, 1'b0, 3'd0, 4'd5, 3'd0); tick();
    drive(64'd6, 1'b0, 1'b0, 3'd0, 4'd6, 3'd0);
    out_ready = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    chk("lit_fl_out_valid", 64'(out_valid), 64'd0);
    chk("lit_fl_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    drive(64'd7, 1'b0, 1'b0, 3'd0, 4'd7, 3'd0);
    @(negedge clk);
    chk("lit_fl_after_valid", 64'(out_valid), 64'd0);
    chk("lit_fl_after_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_fl_new_tag", 64'(out_tag), 64'd7);
    tick();
    @(negedge clk);
    chk("lit_fl_empty", 64'(out_valid), 64'd0);

    // Streaming
    for (int i = 0; i < 8; i++) begin
      drive(64'(i) << 20, 1'b0, 1'b1, 3'd1, 4'(i + 8), 3'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("lit_stream_valid", 64'(out_valid), 64'd1);
      chk("lit_stream_tag", 64'(out_tag), 64'(i + 8));
    end
    in_valid = 1'b0;
    tick();

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    drive(64'd11, 1'b0, 1'b0, 3'd0, 4'd11, 3'd0); tick();
    drive(64'd12, 1'b0, 1'b0, 3'd0, 4'd12, 3'd0); tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("lit_arst_valid", 64'(out_valid), 64'd0);
    chk("lit_arst_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 31) == 0);
      in_operand     = {$urandom, $urandom};
      in_is_word     = $urandom_range(0, 1) == 1;
      in_is_unsigned = $urandom_range(0, 1) == 1;
      in_rm          = 3'($urandom_range(0, 7));
      frm            = 3'($urandom_range(0, 7));
      in_tag         = 4'($urandom_range(0, 15));
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
